// File: rtl/tt_bin_clock_pkg.sv
// Shared types and default timing constants for the tt_bin_clock front-panel controller.
// Repeat defaults exist only when BIN_CLOCK_SET_AUTOREPEAT_EN is defined.
package tt_bin_clock_pkg;

  // The state code doubles as the field_o encoding seen by the display.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 5;
  localparam int DEF_TIMEOUT_CYCLES  = 1000;
`ifdef BIN_CLOCK_SET_AUTOREPEAT_EN
  localparam int DEF_REPEAT_DELAY    = 50;
  localparam int DEF_REPEAT_RATE     = 10;
`endif

  function automatic state_e next_field(input state_e s);
    case (s)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/bin_clock_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and a registered
// one-cycle rise event (press_o) on each debounced 0->1 transition.
module btn_debounce
  import tt_bin_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            level_prev_q;
  logic            press_q;

  // NOTE: every flop, synchroniser included, uses non-blocking assignment and clears in the
  // same synchronous reset branch so a held button is re-debounced as a fresh press.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        // Count reaches DEBOUNCE_CYCLES on this edge: accept the new level.
        level_q <= sync_q[1];
        cnt_q   <= CntW'(DEBOUNCE_CYCLES);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/bin_clock_set_ctrl.sv
// Time-setting sequencer for tt_bin_clock: RUN/SET_HOUR/SET_MIN/SET_SEC driven by
// debounced mode/up/down buttons. Auto-repeat is built when BIN_CLOCK_SET_AUTOREPEAT_EN is defined.
module bin_clock_set_ctrl
  import tt_bin_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
`ifdef BIN_CLOCK_SET_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
`endif
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       mode_btn_i,
  input  logic       up_btn_i,
  input  logic       down_btn_i,
  output logic       time_set_o,
  output logic       id_switch_o,
  output logic       hour_id_o,
  output logic       minute_id_o,
  output logic       seconds_id_o,
  output logic [1:0] field_o
);

  localparam int TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic mode_level_unused, mode_press;
  logic up_level, up_press;
  logic dn_level, dn_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk_i(clk_i), .reset_ni(reset_ni), .btn_i(mode_btn_i),
    .level_o(mode_level_unused), .press_o(mode_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .clk_i(clk_i), .reset_ni(reset_ni), .btn_i(up_btn_i),
    .level_o(up_level), .press_o(up_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
    .clk_i(clk_i), .reset_ni(reset_ni), .btn_i(down_btn_i),
    .level_o(dn_level), .press_o(dn_press)
  );

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q;
  logic            in_set, up_step, dn_step, rpt_step, rpt_up, step, activity;

  // Mode wins over a simultaneous step; each direction is blocked while the other is held.
  assign in_set  = (state_q != RUN);
  assign up_step = in_set & ~mode_press & up_press & ~dn_level;
  assign dn_step = in_set & ~mode_press & dn_press & ~up_level;
  assign step    = up_step | dn_step | rpt_step;
  assign activity = mode_press | up_press | dn_press | rpt_step;

`ifdef BIN_CLOCK_SET_AUTOREPEAT_EN
  localparam int RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RptW   = $clog2(RptMax + 1);

  logic            rpt_active_q, rpt_up_q, rpt_first_q;
  logic [RptW-1:0] rpt_cnt_q;
  logic            rpt_hold;

  assign rpt_hold = rpt_up_q ? (up_level & ~dn_level) : (dn_level & ~up_level);
  assign rpt_step = rpt_active_q & rpt_hold & in_set & ~mode_press &
                    (rpt_cnt_q == (rpt_first_q ? RptW'(REPEAT_DELAY - 1) : RptW'(REPEAT_RATE - 1)));
  assign rpt_up   = rpt_up_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rpt_active_q <= 1'b0;
      rpt_up_q     <= 1'b1;
      rpt_first_q  <= 1'b0;
      rpt_cnt_q    <= '0;
    end else if (up_step || dn_step) begin
      rpt_active_q <= 1'b1;
      rpt_up_q     <= up_step;
      rpt_first_q  <= 1'b1;
      rpt_cnt_q    <= '0;
    end else if (!rpt_active_q || !rpt_hold || !in_set || mode_press) begin
      rpt_active_q <= 1'b0;
    end else if (rpt_step) begin
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
    end else if (rpt_cnt_q != RptW'(RptMax)) begin
      rpt_cnt_q <= rpt_cnt_q + 1'b1;
    end
  end
`else
  assign rpt_step = 1'b0;
  assign rpt_up   = 1'b1;
`endif

  // NOTE: state_d is assigned before any branch so every path through the block drives it.
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      state_d = next_field(state_q);
    end else if (in_set && !activity && tmr_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= RUN;
      tmr_q        <= '0;
      time_set_o   <= 1'b0;
      id_switch_o  <= 1'b1;
      hour_id_o    <= 1'b0;
      minute_id_o  <= 1'b0;
      seconds_id_o <= 1'b0;
      field_o      <= 2'd0;
    end else begin
      state_q <= state_d;
      // Idle timer: held at zero in RUN, restarted on any press and on every state change.
      if (!in_set || activity || state_d != state_q) begin
        tmr_q <= '0;
      end else if (tmr_q != TmrW'(TIMEOUT_CYCLES)) begin
        tmr_q <= tmr_q + 1'b1;
      end
      time_set_o   <= in_set;
      field_o      <= state_q;
      id_switch_o  <= ~(dn_step | (rpt_step & ~rpt_up));
      hour_id_o    <= step & (state_q == SET_HOUR);
      minute_id_o  <= step & (state_q == SET_MIN);
      seconds_id_o <= step & (state_q == SET_SEC);
    end
  end

endmodule

// File: tb/tb_bin_clock_set_ctrl.sv
// Directed bench for bin_clock_set_ctrl with DEBOUNCE_CYCLES=2, TIMEOUT_CYCLES=20 (default build,
// BIN_CLOCK_SET_AUTOREPEAT_EN undefined): latency, stepping, ignored inputs, timeout, reset.
module tb_bin_clock_set_ctrl;

  localparam int D = 2;
  localparam int T = 20;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       mode_btn_i = 1'b0;
  logic       up_btn_i = 1'b0;
  logic       down_btn_i = 1'b0;
  logic       time_set_o, id_switch_o, hour_id_o, minute_id_o, seconds_id_o;
  logic [1:0] field_o;

  bin_clock_set_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .mode_btn_i(mode_btn_i), .up_btn_i(up_btn_i),
    .down_btn_i(down_btn_i), .time_set_o(time_set_o), .id_switch_o(id_switch_o),
    .hour_id_o(hour_id_o), .minute_id_o(minute_id_o), .seconds_id_o(seconds_id_o),
    .field_o(field_o)
  );

  always #5 clk_i = ~clk_i;

  int compared = 0;
  int mismatched = 0;
  int n_hour, n_min, n_sec, n_up, n_dn, n_multi, n_sw_idle;

  task automatic clear_counts();
    n_hour = 0; n_min = 0; n_sec = 0; n_up = 0; n_dn = 0; n_multi = 0; n_sw_idle = 0;
  endtask

  // Advance one edge and sample 1 time unit later, tallying every strobe cycle.
  task automatic tick();
    int s;
    @(posedge clk_i);
    #1;
    s = int'(hour_id_o) + int'(minute_id_o) + int'(seconds_id_o);
    n_hour += int'(hour_id_o);
    n_min  += int'(minute_id_o);
    n_sec  += int'(seconds_id_o);
    if (s > 1) n_multi++;
    if (s > 0) begin
      if (id_switch_o) n_up++;
      else n_dn++;
    end else if (!id_switch_o) begin
      n_sw_idle++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input string tag, input int eh, input int em, input int es,
                               input int eu, input int ed);
    check({tag, "_hour"}, n_hour, eh);
    check({tag, "_min"}, n_min, em);
    check({tag, "_sec"}, n_sec, es);
    check({tag, "_inc"}, n_up, eu);
    check({tag, "_dec"}, n_dn, ed);
    check({tag, "_multi"}, n_multi, 0);
    check({tag, "_sw_idle"}, n_sw_idle, 0);
  endtask

  // Hold the given buttons for 'hold' edges, release, then let debounce settle.
  task automatic press(input logic m, input logic u, input logic d, input int hold);
    mode_btn_i = m; up_btn_i = u; down_btn_i = d;
    ticks(hold);
    mode_btn_i = 1'b0; up_btn_i = 1'b0; down_btn_i = 1'b0;
    ticks(4);
  endtask

  initial begin
    clear_counts();
    ticks(3);
    check("rst_time_set", time_set_o, 0);
    check("rst_field", field_o, 0);
    check("rst_id_switch", id_switch_o, 1);
    check("rst_strobes", {hour_id_o, minute_id_o, seconds_id_o}, 0);

    reset_ni = 1'b1;
    clear_counts();
    ticks(30);
    check("idle_time_set", time_set_o, 0);
    check("idle_field", field_o, 0);
    check("idle_id_switch", id_switch_o, 1);
    check_strobes("idle", 0, 0, 0, 0, 0);

    clear_counts();
    press(1'b0, 1'b1, 1'b0, 8);
    check_strobes("run_up", 0, 0, 0, 0, 0);
    check("run_up_field", field_o, 0);

    // Mode first sampled at edge k: press event k+4, state k+5, registered outputs k+6.
    mode_btn_i = 1'b1;
    ticks(6);
    mode_btn_i = 1'b0;
    check("mode_early_field", field_o, 0);
    check("mode_early_time_set", time_set_o, 0);
    tick();
    check("mode_hour_field", field_o, 1);
    check("mode_hour_time_set", time_set_o, 1);
    ticks(3);

    press(1'b1, 1'b0, 1'b0, 3);
    check("min_field", field_o, 2);
    check("min_time_set", time_set_o, 1);

    clear_counts();
    press(1'b0, 1'b1, 1'b0, 8);
    check_strobes("min_up", 0, 1, 0, 1, 0);
    check("min_up_switch", id_switch_o, 1);

    clear_counts();
    press(1'b0, 1'b0, 1'b1, 8);
    check_strobes("min_dn", 0, 1, 0, 0, 1);
    check("min_dn_switch", id_switch_o, 1);

    clear_counts();
    up_btn_i = 1'b1;
    tick();
    up_btn_i = 1'b0;
    ticks(4);
    check_strobes("glitch", 0, 0, 0, 0, 0);

    clear_counts();
    press(1'b0, 1'b1, 1'b1, 8);
    check_strobes("overlap", 0, 0, 0, 0, 0);
    check("overlap_field", field_o, 2);

    clear_counts();
    press(1'b1, 1'b1, 1'b0, 6);
    check_strobes("mode_up", 0, 0, 0, 0, 0);
    check("mode_up_field", field_o, 3);

    // SEC entered at f_k+5; timer hits T-1 after f_k+24, RUN at f_k+25, outputs at f_k+26.
    ticks(16);
    check("tmo_hold_time_set", time_set_o, 1);
    check("tmo_hold_field", field_o, 3);
    tick();
    check("tmo_time_set", time_set_o, 0);
    check("tmo_field", field_o, 0);

    press(1'b1, 1'b0, 1'b0, 3);
    check("hour2_field", field_o, 1);
    clear_counts();
    press(1'b0, 1'b1, 1'b0, 8);
    check_strobes("hour_up", 1, 0, 0, 1, 0);

    // Reset in SET_HOUR with mode held through it: re-pressed once debounce completes.
    mode_btn_i = 1'b1;
    reset_ni = 1'b0;
    tick();
    check("mid_rst_time_set", time_set_o, 0);
    check("mid_rst_field", field_o, 0);
    check("mid_rst_strobes", {hour_id_o, minute_id_o, seconds_id_o}, 0);
    check("mid_rst_id_switch", id_switch_o, 1);
    ticks(2);
    reset_ni = 1'b1;
    ticks(6);
    check("held_early_field", field_o, 0);
    tick();
    check("held_field", field_o, 1);
    check("held_time_set", time_set_o, 1);
    mode_btn_i = 1'b0;
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
